vga_dtg: RTL and testbench



---
 rtl/vga_dtg_pkg.sv | 32 +++
 rtl/vga_dtg_if.sv | 20 ++
 rtl/vga_dtg.sv | 84 ++++++++
 tb/tb_vga_dtg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_dtg_pkg.sv
// Shared VGA timing constants and types for the display timing generator and renderer.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_dtg_pkg;

  localparam int unsigned CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam bit          HS_POL   = 1'b0;
  localparam bit          VS_POL   = 1'b0;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [START, END).
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_dtg_if.sv
// Timing outputs of the display timing generator as seen by the renderer.
interface vga_dtg_if;
  import vga_dtg_pkg::*;

  logic        video_on;
  logic        horiz_sync;
  logic        vert_sync;
  cnt_t        pixel_row;
  cnt_t        pixel_column;
  logic [31:0] pix_num;

  modport master (
    output video_on, horiz_sync, vert_sync, pixel_row, pixel_column, pix_num
  );

  modport slave (
    input video_on, horiz_sync, vert_sync, pixel_row, pixel_column, pix_num
  );

endinterface

// File: rtl/vga_dtg.sv
// Display timing generator: free-running pixel/line counters with registered sync,
// active-video and linear pixel index, all decoded from the next counter position.
module vga_dtg #(
  parameter int unsigned H_ACTIVE = vga_dtg_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_dtg_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_dtg_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_dtg_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_dtg_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_dtg_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_dtg_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_dtg_pkg::V_BP,
  parameter bit          HS_POL   = vga_dtg_pkg::HS_POL,
  parameter bit          VS_POL   = vga_dtg_pkg::VS_POL
) (
  input  logic       clock,
  input  logic       rst,
  vga_dtg_if.master  vga
);
  import vga_dtg_pkg::*;

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t HLast   = cnt_t'(HTotal - 1);
  localparam cnt_t VLast   = cnt_t'(VTotal - 1);
  localparam cnt_t HActive = cnt_t'(H_ACTIVE);
  localparam cnt_t VActive = cnt_t'(V_ACTIVE);
  localparam cnt_t HsStart = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HsEnd   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VsStart = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VsEnd   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t        h_q, h_d;
  cnt_t        v_q, v_d;
  logic        h_wrap;
  logic        video_on_q, video_on_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [31:0] pix_num_q, pix_num_d;

  // Outputs are decoded from the next position so they line up with the counters.
  always_comb begin
    h_wrap = (h_q == HLast);
    h_d    = h_wrap ? '0 : h_q + cnt_t'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? '0 : v_q + cnt_t'(1);
    end

    video_on_d = (h_d < HActive) && (v_d < VActive);
    hs_d       = sync_level((h_d >= HsStart) && (h_d < HsEnd), HS_POL);
    vs_d       = sync_level((v_d >= VsStart) && (v_d < VsEnd), VS_POL);
    pix_num_d  = '0;
    if (video_on_d) begin
      pix_num_d = 32'(v_d) * 32'(H_ACTIVE) + 32'(h_d);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      video_on_q <= 1'b1;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      pix_num_q  <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      video_on_q <= video_on_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      pix_num_q  <= pix_num_d;
    end
  end

  assign vga.pixel_column = h_q;
  assign vga.pixel_row    = v_q;
  assign vga.video_on     = video_on_q;
  assign vga.horiz_sync   = hs_q;
  assign vga.vert_sync    = vs_q;
  assign vga.pix_num      = pix_num_q;

endmodule

// File: tb/tb_vga_dtg.sv
// Bench for vga_dtg: default-timing instance plus a reduced-timing, positive-polarity instance,
// both compared every cycle against a position model derived from cycles since reset.
`timescale 1ns/1ps
module tb_vga_dtg;

  typedef logic [58:0] pk_t;  // {video_on, hsync, vsync, row[12], col[12], pix[32]}

  logic   clock = 1'b0;
  logic   rst   = 1'b1;
  longint n     = 0;
  int     asserts = 0;
  int     fails   = 0;

  vga_dtg_if if_def ();
  vga_dtg_if if_sm ();

  vga_dtg dut_def (
    .clock (clock),
    .rst   (rst),
    .vga   (if_def)
  );

  vga_dtg #(
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (8), .H_BP (6),
    .V_ACTIVE (30), .V_FP (3), .V_SYNC (2), .V_BP (5),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut_sm (
    .clock (clock),
    .rst   (rst),
    .vga   (if_sm)
  );

  always #5 clock = ~clock;

  // Cycles since the last reset edge; position follows from plain division.
  always @(posedge clock) n <= rst ? 64'd0 : n + 64'd1;

  function automatic pk_t model(input longint cyc, input int ha, hf, hs, hb, va, vf, vs, vb,
                                input bit hp, vp);
    int     ht = ha + hf + hs + hb;
    int     vt = va + vf + vs + vb;
    longint h  = cyc % ht;
    longint v  = (cyc / ht) % vt;
    logic   von, hsl, vsl;
    logic [31:0] pix;
    von = (h < ha) && (v < va);
    hsl = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    vsl = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    pix = von ? 32'(v * ha + h) : 32'd0;
    return {von, hsl, vsl, 12'(v), 12'(h), pix};
  endfunction

  function automatic pk_t exp_def();
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic pk_t exp_sm();
    return model(n, 40, 4, 8, 6, 30, 3, 2, 5, 1'b1, 1'b1);
  endfunction

  function automatic pk_t obs_def();
    return {if_def.video_on, if_def.horiz_sync, if_def.vert_sync,
            if_def.pixel_row, if_def.pixel_column, if_def.pix_num};
  endfunction

  function automatic pk_t obs_sm();
    return {if_sm.video_on, if_sm.horiz_sync, if_sm.vert_sync,
            if_sm.pixel_row, if_sm.pixel_column, if_sm.pix_num};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clock);
      asserts++;
      if (obs_def() !== pk_t'({1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 32'd0})) begin
        fails++;
        $display("FAIL reset_def got %h want %h", obs_def(), {3'b111, 56'd0});
      end
      asserts++;
      if (obs_sm() !== pk_t'({1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 32'd0})) begin
        fails++;
        $display("FAIL reset_sm got %h want %h", obs_sm(), {3'b100, 56'd0});
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clock);
      asserts++;
      if (if_def.pixel_column !== 12'(i) || if_def.pixel_row !== 12'd0 ||
          if_def.pix_num !== 32'(i) || if_def.video_on !== 1'b1) begin
        fails++;
        $display("FAIL release_step%0d got col=%0d row=%0d pix=%0d von=%b want col=%0d row=0",
                 i, if_def.pixel_column, if_def.pixel_row, if_def.pix_num, if_def.video_on, i);
      end
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    int von_cnt = 0;
    bit found = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      asserts++;
      if (obs_def() !== exp_def()) begin
        fails++;
        $display("FAIL line_def n=%0d got %h want %h", n, obs_def(), exp_def());
      end
      if (if_def.horiz_sync === 1'b0) hs_cnt++;
      if (if_def.video_on === 1'b1) von_cnt++;
    end
    asserts++;
    if (hs_cnt != 96) begin
      fails++;
      $display("FAIL hsync_width got %0d want 96", hs_cnt);
    end
    asserts++;
    if (von_cnt != 640) begin
      fails++;
      $display("FAIL line_active got %0d want 640", von_cnt);
    end
    for (int i = 0; i < 1600 && !found; i++) begin
      @(negedge clock);
      if (if_def.pixel_column === 12'd0 && if_def.pixel_row === 12'd2) found = 1;
    end
    asserts++;
    if (!found || if_def.pix_num !== 32'd1280) begin
      fails++;
      $display("FAIL line_start_pix found=%0d got %0d want 1280", found, if_def.pix_num);
    end
  endtask

  task automatic test_frame();
    int  vs_cnt = 0, hs_cnt = 0, von_cnt = 0, len = 0;
    bit  found = 0;
    for (int i = 0; i < 2400 && !found; i++) begin
      @(negedge clock);
      asserts++;
      if (obs_sm() !== exp_sm()) begin
        fails++;
        $display("FAIL frame_sm n=%0d got %h want %h", n, obs_sm(), exp_sm());
      end
      if (if_sm.pixel_column === 12'd0 && if_sm.pixel_row === 12'd0) found = 1;
    end
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clock);
      len++;
      asserts++;
      if (obs_sm() !== exp_sm()) begin
        fails++;
        $display("FAIL frame_sm n=%0d got %h want %h", n, obs_sm(), exp_sm());
      end
      if (if_sm.vert_sync === 1'b1) vs_cnt++;
      if (if_sm.horiz_sync === 1'b1) hs_cnt++;
      if (if_sm.video_on === 1'b1) von_cnt++;
      if (if_sm.pixel_column === 12'd0 && if_sm.pixel_row === 12'd0) found = 1;
    end
    asserts++;
    if (len != 2320) begin
      fails++;
      $display("FAIL frame_len got %0d want 2320", len);
    end
    asserts++;
    if (vs_cnt != 116 || hs_cnt != 320 || von_cnt != 1200) begin
      fails++;
      $display("FAIL frame_counts got vs=%0d hs=%0d von=%0d want vs=116 hs=320 von=1200",
               vs_cnt, hs_cnt, von_cnt);
    end
  endtask

  task automatic test_last_visible();
    bit found = 0;
    for (int i = 0; i < 2400 && !found; i++) begin
      @(negedge clock);
      if (if_sm.pixel_column === 12'd39 && if_sm.pixel_row === 12'd29) found = 1;
    end
    asserts++;
    if (!found || if_sm.pix_num !== 32'd1199 || if_sm.video_on !== 1'b1) begin
      fails++;
      $display("FAIL last_pixel found=%0d got pix=%0d von=%b want pix=1199 von=1",
               found, if_sm.pix_num, if_sm.video_on);
    end
    @(negedge clock);
    asserts++;
    if (if_sm.pixel_column !== 12'd40 || if_sm.video_on !== 1'b0 || if_sm.pix_num !== 32'd0) begin
      fails++;
      $display("FAIL past_last got col=%0d von=%b pix=%0d want col=40 von=0 pix=0",
               if_sm.pixel_column, if_sm.video_on, if_sm.pix_num);
    end
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (if_sm.pixel_column === 12'd0 && if_sm.pixel_row === 12'd30) found = 1;
    end
    asserts++;
    if (!found || if_sm.video_on !== 1'b0 || if_sm.pix_num !== 32'd0) begin
      fails++;
      $display("FAIL first_blank_line found=%0d got von=%b pix=%0d want von=0 pix=0",
               found, if_sm.video_on, if_sm.pix_num);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clock);
      if (if_def.pixel_column === 12'd300 && if_def.pixel_row === 12'd20) found = 1;
    end
    asserts++;
    if (!found) begin
      fails++;
      $display("FAIL mid_reset_reach got col=%0d row=%0d want col=300 row=20",
               if_def.pixel_column, if_def.pixel_row);
    end
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    asserts++;
    if (obs_def() !== pk_t'({1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 32'd0})) begin
      fails++;
      $display("FAIL mid_reset_def got %h want %h", obs_def(), {3'b111, 56'd0});
    end
    repeat (5) begin
      @(negedge clock);
      asserts++;
      if (obs_def() !== exp_def()) begin
        fails++;
        $display("FAIL resume_def n=%0d got %h want %h", n, obs_def(), exp_def());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int run = $urandom_range(1, 2500);
      int hold = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) begin
        @(negedge clock);
        asserts++;
        if (obs_def() !== exp_def()) begin
          fails++;
          $display("FAIL rand_def n=%0d got %h want %h", n, obs_def(), exp_def());
        end
        asserts++;
        if (obs_sm() !== exp_sm()) begin
          fails++;
          $display("FAIL rand_sm n=%0d got %h want %h", n, obs_sm(), exp_sm());
        end
      end
      rst = 1'b1;
      repeat (hold) begin
        @(negedge clock);
        asserts++;
        if (obs_sm() !== pk_t'({1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 32'd0})) begin
          fails++;
          $display("FAIL rand_hold_sm got %h want %h", obs_sm(), {3'b100, 56'd0});
        end
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_last_visible();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
